// File: rtl/systolic_sched_if.sv
// Control/status bundle between a systolic-array sequencer and whoever starts
// the passes and consumes the array enables.
interface systolic_sched_if #(
    parameter int DIM = 8,
    parameter int CW  = $clog2(3*DIM),
    parameter int RW  = (DIM > 1) ? $clog2(DIM) : 1
);
    logic           start;
    logic           accum;
    logic           stall;
    logic           busy;
    logic           done;
    logic           arr_en;
    logic           arr_wren;
    logic [RW-1:0]  c_row;
    logic [CW-1:0]  feed_k;
    logic [DIM-1:0] a_vld;
    logic [DIM-1:0] b_vld;

    modport master (
        output start, accum, stall,
        input  busy, done, arr_en, arr_wren, c_row, feed_k, a_vld, b_vld
    );

    modport slave (
        input  start, accum, stall,
        output busy, done, arr_en, arr_wren, c_row, feed_k, a_vld, b_vld
    );
endinterface

// File: rtl/systolic_sched.sv
// Sequencer for a DIM x DIM systolic MAC array: optional C preload, skewed
// operand feed, and a single-cycle completion pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; accum chooses LOAD_C or straight to MAC
//   LOAD_C | one C row written per non-stalled cycle, c_row 0..DIM-1
//   MAC    | operand feed, feed_k 0..3*DIM-3 with diagonal skew masks
//   DONE   | one-cycle done pulse, array idle, back to IDLE
module systolic_sched #(
    parameter int DIM = 8,
    parameter int CW  = $clog2(3*DIM)
) (
    input  logic             clk,
    input  logic             rst,
    systolic_sched_if.slave  bus
);
    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(DIM - 1);
    localparam logic [CW-1:0] K_LAST   = CW'(3*DIM - 3);

    typedef enum logic [1:0] {IDLE, LOAD_C, MAC, DONE} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] c_row_q;
    logic [CW-1:0] feed_k_q;
    logic          row_last;
    logic          k_last;

    assign row_last = (c_row_q == ROW_LAST);
    assign k_last   = (feed_k_q == K_LAST);

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode; a stalled cycle simply holds the current state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = bus.accum ? MAC : LOAD_C;
            LOAD_C:  if (!bus.stall && row_last) state_d = MAC;
            MAC:     if (!bus.stall && k_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row and feed counters advance only on non-stalled cycles of their own
    // phase and clear on their terminal value, so they never wrap past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_row_q  <= '0;
            feed_k_q <= '0;
        end else begin
            case (state_q)
                LOAD_C: begin
                    feed_k_q <= '0;
                    if (!bus.stall) c_row_q <= row_last ? '0 : c_row_q + 1'b1;
                end
                MAC: begin
                    c_row_q <= '0;
                    if (!bus.stall) feed_k_q <= k_last ? '0 : feed_k_q + 1'b1;
                end
                default: begin
                    c_row_q  <= '0;
                    feed_k_q <= '0;
                end
            endcase
        end
    end

    // Output decode from registered state; stall only gates the array
    // enables and operand masks, never busy or done.
    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == DONE);
        bus.arr_en   = 1'b0;
        bus.arr_wren = 1'b0;
        bus.c_row    = '0;
        bus.feed_k   = '0;
        bus.a_vld    = '0;
        bus.b_vld    = '0;
        case (state_q)
            LOAD_C: begin
                bus.c_row    = c_row_q;
                bus.arr_en   = !bus.stall;
                bus.arr_wren = !bus.stall;
            end
            MAC: begin
                bus.feed_k = feed_k_q;
                bus.arr_en = !bus.stall;
                if (!bus.stall) begin
                    for (int i = 0; i < DIM; i++) begin
                        bus.a_vld[i] = (int'(feed_k_q) >= i) && (int'(feed_k_q) <= i + DIM - 1);
                    end
                    bus.b_vld = bus.a_vld;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/systolic_sched.md
SYSTOLIC_SCHED -- requirements
Module: systolic_sched

Interface
REQ-001: Parameter DIM, default 8, is the edge length of the square systolic array of MAC cells being sequenced.
REQ-002: Parameter CW, default $clog2(3*DIM), is the width of the feed counter.
REQ-003: clk  input  1  single clock; all state updates on posedge clk.
REQ-004: rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005: start  input  1  request one matrix-multiply pass; sampled only in IDLE.
REQ-006: accum  input  1  sampled with start; 1 means skip LOAD_C and accumulate onto the held C values.
REQ-007: stall  input  1  1 freezes the sequence for that cycle.
REQ-008: busy  output  1  high in every state except IDLE.
REQ-009: done  output  1  one-cycle pulse in DONE state.
REQ-010: arr_en  output  1  drives en of every MAC cell.
REQ-011: arr_wren  output  1  drives WrEn of every MAC cell.
REQ-012: c_row  output  $clog2(DIM)  row index of the C preload word presented this cycle.
REQ-013: feed_k  output  CW  feed step index during MAC.
REQ-014: a_vld  output  DIM  per-row mask; bit i enables a non-zero A operand into row i.
REQ-015: b_vld  output  DIM  per-column mask; bit j enables a non-zero B operand into column j.

Function
REQ-016: The FSM shall have states IDLE, LOAD_C, MAC and DONE.
REQ-017: IDLE->LOAD_C when start=1 and accum=0; IDLE->MAC when start=1 and accum=1; otherwise remain in IDLE.
REQ-018: LOAD_C shall last DIM non-stalled cycles with c_row counting 0..DIM-1, arr_en=1, arr_wren=1, then go to MAC.
REQ-019: MAC shall last 3*DIM-2 non-stalled cycles with feed_k counting 0..3*DIM-3, arr_en=1, arr_wren=0, then go to DONE.
REQ-020: In MAC, a_vld[i]=1 iff i <= feed_k <= i+DIM-1; b_vld[j]=1 iff j <= feed_k <= j+DIM-1 (diagonal skew); the datapath reads element index feed_k-i (feed_k-j).
REQ-021: Outside MAC, a_vld and b_vld shall be all zeros; outside LOAD_C, c_row and arr_wren shall be 0; outside MAC, feed_k shall be 0.
REQ-022: DONE shall last exactly one cycle with done=1, arr_en=0, then return to IDLE.
REQ-023: When stall=1 in LOAD_C or MAC, arr_en and arr_wren shall be 0, a_vld and b_vld shall be 0, and state, c_row and feed_k shall hold.
REQ-024: stall shall have no effect in IDLE or DONE.
REQ-025: start asserted while busy=1 shall be ignored (not queued).
REQ-026: start asserted in the DONE cycle shall be ignored; a new pass requires start in IDLE.
REQ-027: Counters shall never exceed their terminal values; no wrap beyond DIM-1 or 3*DIM-3.
REQ-028: All outputs shall be registered or decoded from registered state only; no combinational path from start or stall to busy or done.

Reset
REQ-029: While rst=1, on every posedge the state shall be IDLE with c_row=0, feed_k=0, busy=0, done=0, arr_en=0, arr_wren=0, a_vld=0 and b_vld=0.
REQ-030: rst asserted mid-pass (LOAD_C or MAC) shall abort the pass at the next posedge with no done pulse; rst takes priority over start and stall.

Verification (DIM=4)
REQ-031: start=1, accum=0 at edge 0 -> LOAD_C with c_row 0,1,2,3 and arr_wren=1; MAC with feed_k 0..9; done=1 for exactly one cycle; busy high for 15 cycles total.
REQ-032: start=1, accum=1 -> no arr_wren cycle; MAC runs 10 cycles; done follows; busy high for 11 cycles.
REQ-033: Check masks in MAC: feed_k=0 -> a_vld=0001; feed_k=3 -> 1111; feed_k=5 -> 1100; feed_k=9 -> 0000 (b_vld identical).
REQ-034: stall=1 for 3 cycles at feed_k=2 -> feed_k holds at 2, arr_en=0 and masks 0 during the stall, pass lengthens by 3 cycles, done still pulses once.
REQ-035: start pulsed at feed_k=5 and again in the DONE cycle -> ignored; FSM in IDLE afterwards with busy=0.
REQ-036: rst=1 at c_row=2 -> next cycle IDLE with all outputs 0 and no done; a fresh start then completes a normal 15-cycle pass.
